// File: rtl/cpu_prog_loader.sv
// rtl/cpu_prog_loader.sv - nibble-stream loader for the 4-bit CPU instruction store
// Accepts DEPTH program nibbles plus a checksum, then releases the CPU from reset.
module cpu_prog_loader #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              cpu_rstn,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-1:0] wr_ptr
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    RELEASE,
    RUN,
    ERR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] sum;
  logic              rel_cnt;
  logic              xfer;

  assign in_ready  = (state == LOAD) || (state == CHECK);
  assign cpu_rstn  = (state == RUN);
  assign load_done = (state == RUN);
  assign load_err  = (state == ERR);
  assign rd_data   = mem[rd_addr];

  // A restart request swallows any handshake presented in the same cycle.
  assign xfer = in_valid && in_ready && !load_start;

  always_comb begin
    state_nxt = state;
    if (load_start) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD:    if (xfer && wr_ptr == ADDR_W'(DEPTH - 1)) state_nxt = CHECK;
        CHECK:   if (xfer) state_nxt = (in_data == sum) ? RELEASE : ERR;
        RELEASE: if (rel_cnt) state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      sum     <= '0;
      rel_cnt <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_nxt;
      if (load_start) begin
        wr_ptr <= '0;
        sum    <= '0;
      end else if (xfer && state == LOAD) begin
        mem[wr_ptr] <= in_data;
        sum         <= sum + in_data;
        wr_ptr      <= wr_ptr + ADDR_W'(1);
      end
      // Cleared on entry so RELEASE always spans exactly two cycles.
      rel_cnt <= (state == RELEASE) ? ~rel_cnt : 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_prog_loader.sv
// tb/tb_cpu_prog_loader.sv - self-checking bench for cpu_prog_loader
`timescale 1ns/1ps
module tb_cpu_prog_loader;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_start = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              cpu_rstn;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W-1:0] wr_ptr;

  cpu_prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .cpu_rstn(cpu_rstn), .load_done(load_done), .load_err(load_err), .wr_ptr(wr_ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] prog;
    logic [3:0]  csum;
    bit          gaps;
    bit          ok;
  } vec_t;

  typedef struct {
    logic [2:0] addr;
    logic [3:0] data;
  } wr_t;

  vec_t       vecs[6];
  wr_t        sb[$];
  logic [3:0] model[8];
  logic [2:0] exp_ptr;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("ready_after_start", in_ready, 1);
    check("wr_ptr_after_start", wr_ptr, 0);
    exp_ptr = '0;
    sb.delete();
  endtask

  task automatic send(input logic [3:0] d, input bit gap);
    int budget;
    if (gap) begin
      in_valid = 1'b0;
      step();
    end
    in_valid = 1'b1;
    in_data  = d;
    budget   = 0;
    while (!in_ready && budget < 16) begin
      step();
      budget++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got in_ready=0 after %0d cycles, expected 1", budget);
    end
    step();
    in_valid = 1'b0;
    sb.push_back('{addr: exp_ptr, data: d});
    model[exp_ptr] = d;
    exp_ptr = exp_ptr + 3'd1;
  endtask

  task automatic finish_load(input logic [3:0] csum, input bit ok);
    check("ready_in_check", in_ready, 1);
    check("wr_ptr_wrapped", wr_ptr, 0);
    in_valid = 1'b1;
    in_data  = csum;
    step();
    in_valid = 1'b0;
    if (ok) begin
      check("rel1_cpu_rstn", cpu_rstn, 0);
      check("rel1_in_ready", in_ready, 0);
      step();
      check("rel2_cpu_rstn", cpu_rstn, 0);
      check("rel2_load_done", load_done, 0);
      step();
      check("run_cpu_rstn", cpu_rstn, 1);
      check("run_load_done", load_done, 1);
      check("run_load_err", load_err, 0);
    end else begin
      check("err_load_err", load_err, 1);
      check("err_cpu_rstn", cpu_rstn, 0);
      check("err_in_ready", in_ready, 0);
      check("err_load_done", load_done, 0);
      step();
      check("err_hold_load_err", load_err, 1);
      check("err_hold_cpu_rstn", cpu_rstn, 0);
    end
  endtask

  task automatic readback_sb();
    wr_t w;
    while (sb.size() > 0) begin
      w = sb.pop_front();
      rd_addr = w.addr;
      #1;
      check("rd_data_sb", rd_data, w.data);
      step();
    end
  endtask

  task automatic readback_model();
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = 3'(a);
      #1;
      check("rd_data_model", rd_data, model[a]);
      step();
    end
  endtask

  initial begin
    logic [31:0] p;

    vecs[0] = '{prog: 32'h87654321, csum: 4'h4, gaps: 1'b0, ok: 1'b1};
    vecs[1] = '{prog: 32'h87654321, csum: 4'h5, gaps: 1'b0, ok: 1'b0};
    vecs[2] = '{prog: 32'h87654321, csum: 4'h4, gaps: 1'b0, ok: 1'b1};
    vecs[3] = '{prog: 32'hFFFFFFFF, csum: 4'h8, gaps: 1'b1, ok: 1'b1};
    vecs[4] = '{prog: 32'h00000000, csum: 4'h0, gaps: 1'b1, ok: 1'b1};
    vecs[5] = '{prog: 32'h88888888, csum: 4'h1, gaps: 1'b0, ok: 1'b0};
    for (int a = 0; a < DEPTH; a++) model[a] = 4'h0;
    exp_ptr = '0;

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 0);
    check("rst_cpu_rstn", cpu_rstn, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_err", load_err, 0);
    check("rst_wr_ptr", wr_ptr, 0);
    readback_model();

    for (int v = 0; v < 6; v++) begin
      p = vecs[v].prog;
      start_load();
      for (int i = 0; i < DEPTH; i++) send(p[4*i +: 4], vecs[v].gaps);
      finish_load(vecs[v].csum, vecs[v].ok);
      readback_sb();
    end

    // Restart three nibbles in, with a live handshake that must be dropped.
    start_load();
    send(4'h3, 1'b0);
    send(4'h2, 1'b0);
    send(4'h1, 1'b0);
    rd_addr    = 3'd3;
    in_valid   = 1'b1;
    in_data    = 4'hA;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    in_valid   = 1'b0;
    check("abort_wr_ptr", wr_ptr, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_no_write", rd_data, model[3]);
    sb.delete();
    exp_ptr = '0;
    p = 32'h76543219;
    for (int i = 0; i < DEPTH; i++) send(p[4*i +: 4], 1'b0);
    finish_load(4'h5, 1'b1);
    readback_sb();

    load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("rerun_cpu_rstn", cpu_rstn, 0);
    check("rerun_load_done", load_done, 0);
    check("rerun_in_ready", in_ready, 1);
    readback_model();

    start_load();
    for (int i = 0; i < 5; i++) send(4'(i + 6), 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_cpu_rstn", cpu_rstn, 0);
    check("midrst_load_done", load_done, 0);
    check("midrst_load_err", load_err, 0);
    check("midrst_wr_ptr", wr_ptr, 0);
    sb.delete();
    for (int a = 0; a < DEPTH; a++) model[a] = 4'h0;
    readback_model();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_prog_loader.md
# cpu_prog_loader

Program loader for the 4-bit CPU's 8-entry instruction ROM. It accepts a nibble stream over a valid/ready handshake and writes it into its own 8x4 instruction store. It verifies a trailing 4-bit checksum, then releases the CPU from reset. The CPU reads instructions back through a combinational port addressed by its PC, so this block is the writer end of the CPU's ROM-read path.

## Interface
Parameters:
- DEPTH, 8, number of instruction words (power of two)
- ADDR_W, 3, address width, log2(DEPTH)
- DATA_W, 4, instruction/nibble width

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- load_start  input  1  one-cycle request to begin a (re)load
- in_valid  input  1  in_data holds a nibble
- in_data  input  DATA_W  program nibble, or checksum nibble
- in_ready  output  1  loader will accept in_data this cycle
- rd_addr  input  ADDR_W  CPU fetch address (CPU PC)
- rd_data  output  DATA_W  instruction at rd_addr (combinational read)
- cpu_rstn  output  1  active-low reset to CPU; low unless state is RUN
- load_done  output  1  high in RUN
- load_err  output  1  high in ERR
- wr_ptr  output  ADDR_W  next write address (debug)

## Operation
- Storage: DEPTH x DATA_W registers; all cleared to 0 on rst.
- Running checksum `sum`: DATA_W bits, modulo-2^DATA_W addition of accepted program nibbles.
- Handshake: transfer occurs on a rising edge with in_valid && in_ready. in_data must be stable while in_valid is high. in_valid may drop at any time; gaps are allowed.
- FSM states: IDLE, LOAD, CHECK, RELEASE, RUN, ERR.
  - IDLE: in_ready=0, cpu_rstn=0. load_start goes to LOAD.
  - LOAD: in_ready=1. Each transfer does mem[wr_ptr]<=in_data, sum<=sum+in_data, wr_ptr<=wr_ptr+1. Transfer at wr_ptr==DEPTH-1 goes to CHECK, and wr_ptr wraps to 0.
  - CHECK: in_ready=1. On transfer, in_data==sum goes to RELEASE; otherwise ERR. The checksum nibble is not stored.
  - RELEASE: in_ready=0, cpu_rstn=0, lasts exactly 2 cycles via a 1-bit counter, then goes to RUN.
  - RUN: cpu_rstn=1, load_done=1, in_ready=0.
  - ERR: load_err=1, cpu_rstn=0, in_ready=0. Memory keeps the partial or bad program.
- load_start is honoured in every state. It is highest priority.
  - Next state is LOAD, with wr_ptr<=0 and sum<=0.
  - A handshake in the same cycle is discarded: no write and no sum update.
  - In RUN, this drops cpu_rstn the next cycle.
- rd_data = mem[rd_addr] combinationally in all states. It reflects a write from the cycle after the write edge.

## Timing
- Reset values: state=IDLE, wr_ptr=0, sum=0, in_ready=0, cpu_rstn=0, load_done=0, load_err=0, rd_data=0 for any rd_addr.
- rst asserted mid-load or in RUN behaves identically to power-on reset at the next edge. rst overrides load_start.
- load_start sampled at edge E: in_ready=1 from cycle E+1.
- Minimum load time is DEPTH+1 transfer cycles after LOAD entry.
- Checksum accepted at edge C: RELEASE in cycles C+1 and C+2, and cpu_rstn=1 from cycle C+3.
- Mismatch accepted at edge C: load_err=1 from cycle C+1.
- All outputs except rd_data are decoded from registered state only; no input-to-output combinational paths.

## Test plan
- Reset then load 1,2,3,4,5,6,7,8 with checksum 4 (36 mod 16), back-to-back valid. Required: load_done=1 and cpu_rstn=1 exactly 3 cycles after the checksum transfer; rd_addr 0..7 reads 1..8.
- Same program with checksum 5. Required: load_err=1, cpu_rstn stays 0, in_ready=0. Then reload with checksum 4 and require RUN.
- Load F,F,F,F,F,F,F,F (sum 120 mod 16 = 8) with in_valid toggling every other cycle. Required: exactly 8 writes, checksum 8 accepted, wr_ptr back to 0.
- After 3 nibbles of a load, pulse load_start with in_valid=1 and in_data=A in that cycle. Required: A is discarded, wr_ptr=0 and sum=0 next cycle, and the following 8 nibbles land at addresses 0..7.
- In RUN, pulse load_start. Required: cpu_rstn=0 and load_done=0 the next cycle; memory contents are unchanged until new writes.
- Assert rst during LOAD after 5 nibbles. Required: all outputs at reset values next cycle and all rd_data=0.
